// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - WIDTH-bit shift/rotate register stepped by a DIV-cycle prescaler tick
// Optional input synchronizers and load edge-detect: define PARAM_SHIFT_REG_SYNC_IN_EN.
module param_shift_register #(
  parameter int              WIDTH = 8,
  parameter int              DIV   = 8388608,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             freeze,
  output logic [WIDTH-1:0] data,
  output logic             serial_out,
  output logic             tick,
  output logic             all_ones,
  output logic             all_zeros
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

  logic serial_in_eff;
  logic load_eff;

`ifdef PARAM_SHIFT_REG_SYNC_IN_EN
  logic [1:0] sin_sync_q, sin_sync_d;
  // Third load flop only remembers the previous synchronized level for edge detection.
  logic [2:0] load_sync_q, load_sync_d;

  always_comb begin
    sin_sync_d  = {sin_sync_q[0], serial_in};
    load_sync_d = {load_sync_q[1:0], load};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sin_sync_q  <= '0;
      load_sync_q <= '0;
    end else begin
      sin_sync_q  <= sin_sync_d;
      load_sync_q <= load_sync_d;
    end
  end

  assign serial_in_eff = sin_sync_q[1];
  assign load_eff      = load_sync_q[1] & ~load_sync_q[2];
`else
  assign serial_in_eff = serial_in;
  assign load_eff      = load;
`endif

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             cnt_wrap;

  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign tick     = cnt_wrap && !freeze && !load_eff;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    sout_d = sout_q;
    if (load_eff) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (!freeze) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
      if (tick) begin
        case (mode)
          2'b00: begin
            data_d = {serial_in_eff, data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
          2'b01: begin
            data_d = {data_q[WIDTH-2:0], serial_in_eff};
            sout_d = data_q[WIDTH-1];
          end
          2'b10: begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
          default: begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            sout_d = data_q[WIDTH-1];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= '0;
      data_q <= INIT;
      sout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      sout_q <= sout_d;
    end
  end

  assign data       = data_q;
  assign serial_out = sout_q;
  assign all_ones   = &data_q;
  assign all_zeros  = ~|data_q;

endmodule
